dvp_stream_tx: RTL and testbench
================================

# dvp_stream_tx

Synthetic OV7670-style DVP transmitter: generates `pclk`/`href`/`vsync`/`data` with programmable frame timing and built-in RGB565 test patterns. It drives the pixel side of the camera capture path (cameraControl, frameBuffer_greyScale) without a physical sensor, for board bring-up and for closed-loop benches of the capture → greyscale → edge → VGA chain.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line (2 bytes each).
- `V_ACTIVE`, 480: active lines per frame.
- `H_BLANK`, 144: byte ticks with `href` low after each line.
- `VSYNC_LINES`, 3: lines with `vsync` high.
- `V_BACK`, 17: blank lines after `vsync`.
- `V_FRONT`, 10: blank lines after the last active line.

Ports:
- `clk` input 1: single clock; all logic in this domain.
- `reset` input 1: asynchronous, active-low.
- `enable` input 1: request continuous frames.
- `pattern` input 2: 0 color bars, 1 ramp, 2 checker, 3 solid.
- `solid_color` input 16: RGB565 value for pattern 3.
- `pclk` output 1: pixel clock, `clk`/2, free-running out of reset.
- `href` output 1: high while line bytes are valid.
- `vsync` output 1: high during the sync lines.
- `data` output 8: pixel byte; 0 whenever `href` is low.
- `busy` output 1: high from frame start through end of front porch.
- `frame_done` output 1: one-`clk` pulse at end of each frame.
- `frame_count` output 16: completed frames, wraps.

## Operation
- `phase` toggles every `clk`; `pclk = phase`. Tick = `clk` edge where `phase` goes 1→0 (`pclk` falling). All state, `href`, `vsync`, `data` update only on ticks, so they are stable at the `pclk` rising edge.
- Line = `2*H_ACTIVE + H_BLANK` ticks in every state; `hcnt` counts ticks, `vcnt` counts lines within a state.
- FSM: IDLE → VSYNC (`VSYNC_LINES`) → VBACK (`V_BACK`) → ACTIVE (`V_ACTIVE` lines; `href` high for first `2*H_ACTIVE` ticks) → VFRONT (`V_FRONT`) → VSYNC if `enable`, else IDLE.
- IDLE exits on a tick with `enable`=1; `pattern` and `solid_color` latched on that tick and on each VSYNC entry; stable for the whole frame.
- `enable` dropped mid-frame: frame completes, then IDLE. Never truncated.
- Byte order per pixel: high byte (R[4:0],G[5:3]) then low byte (G[2:0],B[4:0]). x = `hcnt`>>1, y = active line index.
- Pattern 0: 8 bars, width `H_ACTIVE/8`: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Pattern 1: R=x[8:4], G=y[8:3], B=x[8:4].
- Pattern 2: FFFF if x[5]^y[5], else 0000.
- Pattern 3: latched `solid_color`.
- Last VFRONT tick: `frame_done`=1 for that `clk`, `frame_count`+1 (FFFF→0000).
- Counter widths: `$clog2` of the respective maximum; no truncation.

## Timing
- Reset values: `pclk` 0, `href` 0, `vsync` 0, `data` 00, `busy` 0, `frame_done` 0, `frame_count` 0000; FSM IDLE.
- Reset asserted mid-frame: all outputs to reset values immediately (asynchronous); restart only via IDLE.
- `vsync` and `busy` rise on the same tick that samples `enable`=1 in IDLE.
- `href` rises on the first ACTIVE tick; the first `data` byte is valid on that tick. Zero pipeline latency between `href` and `data`.
- Frame length = (`VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT`) × (`2*H_ACTIVE+H_BLANK`) ticks × 2 `clk`.
- `busy` falls on the tick after `frame_done` when returning to IDLE.

## Configuration
- `DVP_TX_LFSR_EN` defined: pattern 3 outputs a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded 0xACE1 at every frame start and advanced once per pixel; `solid_color` is ignored.
- Undefined: pattern 3 is solid `solid_color`; no LFSR logic.

## Structure
- `dvp_tx_pkg`: FSM state enum, pattern codes, color-bar RGB565 constants, LFSR seed and taps.
- One sub-module, `dvp_tx_pattern`: combinational x, y, pattern, latched color → 16-bit RGB565 pixel. The top holds counters, FSM, byte mux, and the LFSR.

## Test plan
Benches use `H_ACTIVE`=8, `V_ACTIVE`=4, `H_BLANK`=4, `VSYNC_LINES`=1, `V_BACK`=1, `V_FRONT`=1.
- Reset released, `enable`=0 → `pclk` toggles every `clk`; all other outputs 0.
- `enable` pulsed, `pattern`=0 → 4 `href` bursts of 16 bytes; each line is FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; frame is 7×20 ticks; one `frame_done`; `frame_count`=1.
- `pattern`=3, `solid_color`=1234 → every active byte pair is 12 34; `data`=00 while `href` low.
- `enable` held, then dropped on active line 2 → frame completes; no further `vsync`; `busy` falls; `frame_count` increments by exactly 1 for that frame.
- Reset asserted mid-line → outputs 0 on the same edge; after release with `enable`=1, the next frame is full-length and correct.
- With `DVP_TX_LFSR_EN`, `pattern`=3 → first pixel AC E1; sequence restarts at AC E1 each frame.

Source files
------------

// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the synthetic DVP transmitter (dvp_stream_tx).
// The DVP_TX_LFSR_EN build option makes pattern 3 output an LFSR sequence.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } pattern_t;

    // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][15:0] BAR_COLORS = {
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// Camera-side DVP pixel bus: pixel clock, line/frame strobes and the byte lane.
interface dvp_tx_if;
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;

    modport master (output pclk, href, vsync, data);
    modport slave  (input  pclk, href, vsync, data);
endinterface

// File: rtl/dvp_tx_pattern.sv
// Combinational test-pattern generator: pixel coordinate and frame settings to RGB565.
module dvp_tx_pattern
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_t      pattern,
    input  logic [15:0]   color,
    output logic [15:0]   pixel
);

    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    int unsigned xw;
    int unsigned yw;
    int unsigned bar;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        xw    = 32'(x);
        yw    = 32'(y);
        bar   = xw / BAR_W;
        pixel = 16'h0000;
        if (bar > 7) bar = 7;
        case (pattern)
            PAT_BARS:    pixel = BAR_COLORS[3'(bar)];
            PAT_RAMP:    pixel = {5'(xw >> 4), 6'(yw >> 3), 5'(xw >> 4)};
            PAT_CHECKER: pixel = 1'((xw ^ yw) >> 5) ? 16'hFFFF : 16'h0000;
            default:     pixel = color;
        endcase
    end

endmodule

// File: rtl/dvp_stream_tx.sv
// Synthetic OV7670-style DVP transmitter: frame timing FSM, byte mux and pattern source.
// Define DVP_TX_LFSR_EN to replace the solid colour of pattern 3 with a per-frame LFSR.
module dvp_stream_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [1:0]   pattern,
    input  logic [15:0]  solid_color,
    dvp_tx_if.master     dvp,
    output logic         busy,
    output logic         frame_done,
    output logic [15:0]  frame_count
);

    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int HW         = cnt_width(LINE_TICKS);
    localparam int VW         = cnt_width(MAX_LINES);
    localparam int XW         = cnt_width(H_ACTIVE);
    localparam int YW         = cnt_width(V_ACTIVE);

    state_t        state, nxt_state;
    logic [HW-1:0] hcnt, nxt_hcnt;
    logic [VW-1:0] vcnt, nxt_vcnt;
    logic          phase;
    logic          tick;
    logic          href_q, vsync_q;
    logic [7:0]    data_q;
    pattern_t      pat_q;
    logic          frame_start, frame_end;
    logic          line_end, last_line, nxt_href;
    int            state_lines;
    logic [15:0]   color_in, pixel;
    logic [7:0]    data_byte;

    // A tick is the clk edge on which pclk falls; everything visible moves only then.
    assign tick = phase;

    always_comb begin
        nxt_state   = state;
        nxt_hcnt    = hcnt;
        nxt_vcnt    = vcnt;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_VBACK:  state_lines = V_BACK;
            ST_ACTIVE: state_lines = V_ACTIVE;
            ST_VFRONT: state_lines = V_FRONT;
            default:   state_lines = VSYNC_LINES;
        endcase
        line_end  = (hcnt == HW'(LINE_TICKS - 1));
        last_line = (vcnt == VW'(state_lines - 1));
        if (tick) begin
            if (state == ST_IDLE) begin
                if (enable) begin
                    nxt_state   = ST_VSYNC;
                    nxt_hcnt    = '0;
                    nxt_vcnt    = '0;
                    frame_start = 1'b1;
                end
            end else begin
                nxt_hcnt = line_end ? '0 : hcnt + HW'(1);
                if (line_end) begin
                    nxt_vcnt = last_line ? '0 : vcnt + VW'(1);
                    if (last_line) begin
                        case (state)
                            ST_VSYNC:  nxt_state = ST_VBACK;
                            ST_VBACK:  nxt_state = ST_ACTIVE;
                            ST_ACTIVE: nxt_state = ST_VFRONT;
                            default: begin
                                frame_end   = 1'b1;
                                frame_start = enable;
                                nxt_state   = enable ? ST_VSYNC : ST_IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Outputs are registered from the next-state counters so href and its data share a tick.
    assign nxt_href  = (nxt_state == ST_ACTIVE) && (int'(nxt_hcnt) < 2 * H_ACTIVE);
    assign data_byte = nxt_hcnt[0] ? pixel[7:0] : pixel[15:8];

`ifdef DVP_TX_LFSR_EN
    logic [15:0] lfsr;
    logic        unused_solid;
    assign unused_solid = ^solid_color;
    assign color_in     = lfsr;
`else
    logic [15:0] solid_q;
    assign color_in = solid_q;
`endif

    dvp_tx_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .x       (XW'(nxt_hcnt >> 1)),
        .y       (YW'(nxt_vcnt)),
        .pattern (pat_q),
        .color   (color_in),
        .pixel   (pixel)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= 1'b0;
            state       <= ST_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            data_q      <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            pat_q       <= PAT_BARS;
`ifdef DVP_TX_LFSR_EN
            lfsr        <= LFSR_SEED;
`else
            solid_q     <= 16'h0000;
`endif
        end else begin
            phase      <= ~phase;
            frame_done <= frame_end;
            if (tick) begin
                state   <= nxt_state;
                hcnt    <= nxt_hcnt;
                vcnt    <= nxt_vcnt;
                href_q  <= nxt_href;
                data_q  <= nxt_href ? data_byte : 8'h00;
                vsync_q <= (nxt_state == ST_VSYNC);
                // Holding busy while the FSM still sits in VFRONT drops it one tick after frame_done.
                busy    <= (nxt_state != ST_IDLE) || (state != ST_IDLE);
                if (frame_start) pat_q <= pattern_t'(pattern);
                if (frame_end) frame_count <= frame_count + 16'd1;
`ifdef DVP_TX_LFSR_EN
                if (frame_start) lfsr <= LFSR_SEED;
                else if (nxt_href && nxt_hcnt[0]) lfsr <= lfsr_step(lfsr);
`else
                if (frame_start) solid_q <= solid_color;
`endif
            end
        end
    end

    assign dvp.pclk  = phase;
    assign dvp.href  = href_q;
    assign dvp.vsync = vsync_q;
    assign dvp.data  = data_q;

endmodule

// File: tb/tb_dvp_stream_tx.sv
// Scoreboard bench for dvp_stream_tx: a frame-level model queues the expected bytes,
// a monitor pops them as the DUT presents href bytes and also watches timing strobes.
module tb_dvp_stream_tx;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LINE      = 2 * H + HB;
    localparam int FRAME_CLK = (VS + VB + V + VF) * LINE * 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        busy, frame_done;
    logic [15:0] frame_count;

    dvp_tx_if dvp_bus ();

    dvp_stream_tx #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern     (pattern),
        .solid_color (solid_color),
        .dvp         (dvp_bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  byte_q [$];

    function automatic logic [15:0] model_pixel(input int p, input logic [15:0] c, input int x, input int y);
        case (p)
            0:       return bar_tab[x / (H / 8)];
            1:       return {5'(x >> 4), 6'(y >> 3), 5'(x >> 4)};
            2:       return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            default: return c;
        endcase
    endfunction

    task automatic push_frame(input int p, input logic [15:0] c);
        logic [15:0] lf;
        logic [15:0] px;
        lf = 16'hACE1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                px = model_pixel(p, c, x, y);
`ifdef DVP_TX_LFSR_EN
                if (p == 3) begin
                    px = lf;
                    lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
                end
`endif
                byte_q.push_back(px[15:8]);
                byte_q.push_back(px[7:0]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    int          clk_n = 0;
    int          vs_clk = 0;
    bit          vs_valid = 0;
    int          done_seen = 0;
    int          vsync_rises = 0;
    int          line_idx = 0;
    int          burst_len = 0;
    logic        prev_pclk = 0, prev_href = 0, prev_vsync = 0, prev_fd = 0;
    logic [15:0] fc_model = 16'h0000;
    logic [7:0]  exp_byte;

    always @(negedge clk) begin
        clk_n++;
        if (!reset) begin
            prev_pclk  = 0;
            prev_href  = 0;
            prev_vsync = 0;
            prev_fd    = 0;
            burst_len  = 0;
            line_idx   = 0;
            vs_valid   = 0;
            fc_model   = 16'h0000;
        end else begin
            check("pclk_toggle", dvp_bus.pclk, !prev_pclk);
            prev_pclk = dvp_bus.pclk;
            if (frame_done) begin
                check("frame_done_width", prev_fd, 0);
                check("busy_at_done", busy, 1);
                fc_model = fc_model + 16'd1;
                check("frame_count_step", frame_count, fc_model);
                if (vs_valid) check("frame_length_clk", clk_n - vs_clk, FRAME_CLK);
                vs_valid = 0;
                done_seen++;
            end
            prev_fd = frame_done;
            if (dvp_bus.vsync && !prev_vsync) begin
                vsync_rises++;
                vs_clk   = clk_n;
                vs_valid = 1;
                line_idx = 0;
            end
            prev_vsync = dvp_bus.vsync;
            if (dvp_bus.pclk) begin
                if (dvp_bus.href) begin
                    if (byte_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pixel_byte: got %0h with no byte expected at %0t", dvp_bus.data, $time);
                    end else begin
                        exp_byte = byte_q.pop_front();
                        check("pixel_byte", dvp_bus.data, exp_byte);
                    end
                    burst_len++;
                end else begin
                    check("data_zero_when_href_low", dvp_bus.data, 8'h00);
                    if (prev_href) begin
                        check("href_burst_len", burst_len, 2 * H);
                        burst_len = 0;
                        line_idx++;
                    end
                end
                prev_href = dvp_bus.href;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_quiet(input string tag);
        check({tag, "_href"},  dvp_bus.href,  0);
        check({tag, "_vsync"}, dvp_bus.vsync, 0);
        check({tag, "_data"},  dvp_bus.data,  8'h00);
        check({tag, "_busy"},  busy,          0);
        check({tag, "_fdone"}, frame_done,    0);
    endtask

    task automatic wait_done(input int target, input string name);
        int budget;
        budget = 4 * FRAME_CLK;
        while (done_seen < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, done_seen, target);
    endtask

    task automatic wait_vsync(input int target, input string name);
        int budget;
        budget = 200;
        while (vsync_rises < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, vsync_rises, target);
    endtask

    task automatic wait_line(input int l, input string name);
        int budget;
        budget = 2 * FRAME_CLK;
        while (!(line_idx == l && dvp_bus.href) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, line_idx, l);
    endtask

    task automatic pulse_enable();
        @(posedge clk); #2 enable = 1'b1;
        repeat (4) @(posedge clk);
        #2 enable = 1'b0;
    endtask

    task automatic check_busy_fall();
        @(negedge clk); #1 check("busy_hold_after_done", busy, 1);
        @(negedge clk); #1 check("busy_fall", busy, 0);
        check("vsync_after_done", dvp_bus.vsync, 0);
    endtask

    // ---------------- main sequence ----------------
    int          base, vr, p;
    logic [15:0] c, c2;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_pclk", dvp_bus.pclk, 0);
        check_quiet("rst");
        check("rst_frame_count", frame_count, 16'h0000);
        @(negedge clk); #2 reset = 1'b1;

        // Idle with enable low: only pclk moves.
        repeat (20) begin
            @(negedge clk); #1;
            check_quiet("idle");
        end

        // Single colour-bar frame from an enable pulse.
        vr = vsync_rises;
        base = done_seen;
        pattern = 2'd0;
        push_frame(0, 16'h0000);
        pulse_enable();
        wait_done(base + 1, "bars_frame_done");
        check_busy_fall();
        repeat (100) @(posedge clk);
        check("bars_single_vsync", vsync_rises, vr + 1);
        check("bars_frame_count", frame_count, 16'd1);
        check("bars_queue_drained", byte_q.size(), 0);

        // Held enable, solid 1234 then a new colour latched at the second VSYNC; drop on line 2.
        vr = vsync_rises;
        base = done_seen;
        c2 = 16'($urandom);
        pattern = 2'd3;
        solid_color = 16'h1234;
        push_frame(3, 16'h1234);
        push_frame(3, c2);
        @(posedge clk); #2 enable = 1'b1;
        wait_vsync(vr + 1, "solid_vsync1");
        @(posedge clk); #2 solid_color = c2;
        wait_done(base + 1, "solid_frame1_done");
        wait_line(2, "solid_line2");
        #2 enable = 1'b0;
        wait_done(base + 2, "solid_frame2_done");
        check_busy_fall();
        repeat (100) @(posedge clk);
        check("solid_no_extra_vsync", vsync_rises, vr + 2);
        check("solid_frame_count", frame_count, 16'd3);
        check("solid_queue_drained", byte_q.size(), 0);

        // Random single frames; inputs are scrambled after the start tick to exercise latching.
        for (int i = 0; i < 3; i++) begin
            base = done_seen;
            p = int'($urandom_range(0, 3));
            c = 16'($urandom);
            pattern = 2'(p);
            solid_color = c;
            push_frame(p, c);
            pulse_enable();
            pattern = 2'($urandom);
            solid_color = 16'($urandom);
            wait_done(base + 1, "rand_frame_done");
            check_busy_fall();
            check("rand_queue_drained", byte_q.size(), 0);
        end
        check("rand_frame_count", frame_count, 16'd6);

        // Asynchronous reset in the middle of an active line, then a clean frame.
        pattern = 2'd0;
        push_frame(0, 16'h0000);
        @(posedge clk); #2 enable = 1'b1;
        wait_line(1, "rst_mid_line1");
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("midrst_pclk", dvp_bus.pclk, 0);
        check_quiet("midrst");
        check("midrst_frame_count", frame_count, 16'h0000);
        byte_q.delete();
        repeat (3) @(negedge clk);
        p = int'($urandom_range(0, 3));
        c = 16'($urandom);
        pattern = 2'(p);
        solid_color = c;
        push_frame(p, c);
        vr = vsync_rises;
        base = done_seen;
        @(negedge clk); #2 reset = 1'b1;
        wait_vsync(vr + 1, "post_rst_vsync");
        @(posedge clk); #2 enable = 1'b0;
        wait_done(base + 1, "post_rst_frame_done");
        check_busy_fall();
        check("post_rst_frame_count", frame_count, 16'd1);
        check("post_rst_queue_drained", byte_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
